// File: rtl/evm_pkg.sv
// evm_pkg: state encodings and saturating-increment helper shared by the ballot controller.
package evm_pkg;
    localparam logic [1:0] LOCKED = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] CLOSED = 2'd2;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v == max) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/evm_sat_counter.sv
// evm_sat_counter: W-bit up-counter that sticks at all-ones.
module evm_sat_counter
    import evm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         at_max
);
    localparam logic [31:0] MAX = 32'((64'd1 << W) - 64'd1);

    assign at_max = &q;

    always_ff @(posedge clk)
        if (reset) q <= '0;
        else if (inc) q <= W'(sat_inc(32'(q), MAX));
endmodule

// File: rtl/evm_ballot_ctrl.sv
// evm_ballot_ctrl: one-vote-per-arm tally with saturating counters, timeout,
// poll close, running leader/tie tracking and an indexed readout mux.
module evm_ballot_ctrl
    import evm_pkg::*;
#(
    parameter int NUM_CAND = 10,
    parameter int CNT_W    = 8,
    parameter int TOT_W    = 12,
    parameter int TIMEOUT  = 1000,
    localparam int CAND_W  = $clog2(NUM_CAND)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ballot_arm,
    input  logic              vote_valid,
    input  logic [CAND_W-1:0] vote_cand,
    input  logic              close_poll,
    input  logic [CAND_W-1:0] rd_sel,
    output logic [CNT_W-1:0]  rd_count,
    output logic [TOT_W-1:0]  total,
    output logic [CAND_W-1:0] leader,
    output logic [CNT_W-1:0]  leader_count,
    output logic              tie,
    output logic              armed,
    output logic              poll_closed,
    output logic              vote_ack,
    output logic              vote_err,
    output logic              timeout,
    output logic              sat
);
    localparam int SLOTS = 2 ** CAND_W;
    localparam int TM_W  = $clog2(TIMEOUT + 1);

    logic [1:0]       state, next_state;
    logic [TM_W-1:0]  timer;
    logic [CNT_W-1:0] cnt [SLOTS];
    logic             cnt_max [SLOTS];
    logic             total_max, in_range, accept, err, expire;
    logic [CNT_W-1:0] n;

    assign in_range = 32'(vote_cand) < NUM_CAND;
    assign accept   = state == ARMED && !close_poll && vote_valid && in_range;
    assign err      = state == ARMED && !close_poll && vote_valid && !in_range;
    assign expire   = state == ARMED && !close_poll && !accept && timer == TM_W'(TIMEOUT - 1);

    assign next_state = (close_poll || state == CLOSED) ? CLOSED :
                        (state == ARMED) ? ((accept || expire) ? LOCKED : ARMED) :
                        (ballot_arm ? ARMED : LOCKED);

    assign n           = cnt[vote_cand] + CNT_W'(1);
    assign rd_count    = cnt[rd_sel];
    assign armed       = state == ARMED;
    assign poll_closed = state == CLOSED;

    // Index space is padded to a power of two so out-of-range selects read zero.
    for (genvar i = 0; i < SLOTS; i++) begin : g_cand
        if (i < NUM_CAND) begin : g_real
            evm_sat_counter #(.W(CNT_W)) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (accept && vote_cand == CAND_W'(i)),
                .q     (cnt[i]),
                .at_max(cnt_max[i])
            );
        end else begin : g_pad
            assign cnt[i]     = '0;
            assign cnt_max[i] = 1'b0;
        end
    end

    evm_sat_counter #(.W(TOT_W)) u_total (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .q     (total),
        .at_max(total_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOCKED;
            timer        <= '0;
            vote_ack     <= 1'b0;
            vote_err     <= 1'b0;
            timeout      <= 1'b0;
            leader       <= '0;
            leader_count <= '0;
            tie          <= 1'b0;
            sat          <= 1'b0;
        end else begin
            state    <= next_state;
            timer    <= (state == ARMED && next_state == ARMED) ? timer + TM_W'(1) : '0;
            vote_ack <= accept;
            vote_err <= err;
            timeout  <= expire;
            sat      <= sat || (accept && (cnt_max[vote_cand] || total_max));
            // A vote clipped by saturation leaves the standings untouched.
            if (accept && !cnt_max[vote_cand]) begin
                if (vote_cand == leader) begin
                    leader_count <= n;
                    tie          <= 1'b0;
                end else if (n > leader_count) begin
                    leader       <= vote_cand;
                    leader_count <= n;
                    tie          <= 1'b0;
                end else if (n == leader_count) begin
                    tie <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// tb_evm_ballot_ctrl: scenario tasks plus a randomized run, all checked against
// a ballot-level reference model kept in plain arrays.
module tb_evm_ballot_ctrl;
    localparam int NC = 10;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1, ballot_arm = 1'b0, vote_valid = 1'b0, close_poll = 1'b0;
    logic [3:0] vote_cand = '0, rd_sel = '0;
    logic [1:0] rd_count, leader_count;
    logic [4:0] total;
    logic [3:0] leader;
    logic       tie, armed, poll_closed, vote_ack, vote_err, timeout, sat;

    logic [1:0] m_cnt [NC];
    logic [4:0] m_total;
    logic [3:0] m_leader;
    logic [1:0] m_lc;
    logic       m_tie, m_sat, m_armed, m_closed, e_ack, e_err, e_to;
    int         m_wait;
    int         compared = 0, mismatched = 0;

    evm_ballot_ctrl #(.NUM_CAND(NC), .CNT_W(2), .TOT_W(5), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ballot_arm(ballot_arm), .vote_valid(vote_valid),
        .vote_cand(vote_cand), .close_poll(close_poll), .rd_sel(rd_sel),
        .rd_count(rd_count), .total(total), .leader(leader), .leader_count(leader_count),
        .tie(tie), .armed(armed), .poll_closed(poll_closed), .vote_ack(vote_ack),
        .vote_err(vote_err), .timeout(timeout), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        foreach (m_cnt[k]) m_cnt[k] = '0;
        m_total = '0; m_leader = '0; m_lc = '0; m_tie = 0; m_sat = 0;
        m_armed = 0; m_closed = 0; e_ack = 0; e_err = 0; e_to = 0; m_wait = 0;
    endtask

    // One ballot-level event per clock: what the voter/officer did and its consequence.
    task automatic model(input logic a, input logic v, input logic [3:0] c, input logic p);
        logic [1:0] nv;
        e_ack = 0; e_err = 0; e_to = 0;
        if (m_closed) return;
        if (p) begin
            m_closed = 1; m_armed = 0;
        end else if (m_armed) begin
            if (v && c < NC) begin
                e_ack = 1; m_armed = 0;
                if (m_cnt[c] == 2'd3) m_sat = 1;
                else begin
                    m_cnt[c] = m_cnt[c] + 2'd1;
                    nv = m_cnt[c];
                    if (c == m_leader) begin m_lc = nv; m_tie = 0; end
                    else if (nv > m_lc) begin m_leader = c; m_lc = nv; m_tie = 0; end
                    else if (nv == m_lc) m_tie = 1;
                end
                if (m_total == 5'd31) m_sat = 1;
                else m_total = m_total + 5'd1;
            end else begin
                if (v) e_err = 1;
                m_wait++;
                if (m_wait == TO) begin m_armed = 0; e_to = 1; end
            end
        end else if (a) begin
            m_armed = 1; m_wait = 0;
        end
    endtask

    function automatic logic [1:0] exp_rd(input logic [3:0] s);
        return (s < NC) ? m_cnt[s] : 2'd0;
    endfunction

    task automatic step(input logic a, input logic v, input logic [3:0] c, input logic p);
        ballot_arm = a; vote_valid = v; vote_cand = c; close_poll = p;
        @(posedge clk);
        model(a, v, c, p);
        #1;
        ballot_arm = 0; vote_valid = 0; close_poll = 0;
    endtask

    task automatic do_reset();
        reset = 1; ballot_arm = 0; vote_valid = 0; close_poll = 0;
        @(posedge clk);
        model_reset();
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (total !== 5'd0) begin mismatched++; $display("FAIL reset_total: got %0d want 0", total); end
        compared++; if ({leader, leader_count, tie, sat} !== 8'd0) begin mismatched++; $display("FAIL reset_leader: got %0d/%0d/%0b/%0b want 0", leader, leader_count, tie, sat); end
        compared++; if ({armed, poll_closed, vote_ack, vote_err, timeout} !== 5'd0) begin mismatched++; $display("FAIL reset_flags: got %b want 00000", {armed, poll_closed, vote_ack, vote_err, timeout}); end
        for (int s = 0; s < 16; s++) begin
            rd_sel = 4'(s); #1;
            compared++; if (rd_count !== 2'd0) begin mismatched++; $display("FAIL reset_rd[%0d]: got %0d want 0", s, rd_count); end
        end
    endtask

    task automatic test_basic_vote();
        do_reset();
        step(1, 0, 0, 0);
        compared++; if (armed !== 1'b1) begin mismatched++; $display("FAIL arm: got %0b want 1", armed); end
        step(0, 1, 3, 0);
        rd_sel = 3; #1;
        compared++; if (rd_count !== 2'd1 || rd_count !== exp_rd(3)) begin mismatched++; $display("FAIL vote3_count: got %0d want 1", rd_count); end
        compared++; if (total !== 5'd1) begin mismatched++; $display("FAIL vote3_total: got %0d want 1", total); end
        compared++; if (vote_ack !== 1'b1 || armed !== 1'b0) begin mismatched++; $display("FAIL vote3_ack: got ack=%0b armed=%0b want 1/0", vote_ack, armed); end
        compared++; if (leader !== 4'd3 || leader_count !== 2'd1) begin mismatched++; $display("FAIL vote3_leader: got %0d/%0d want 3/1", leader, leader_count); end
        step(0, 1, 3, 0);
        #1;
        compared++; if (vote_ack !== 1'b0 || rd_count !== 2'd1 || total !== 5'd1) begin mismatched++; $display("FAIL unarmed_vote: got ack=%0b cnt=%0d tot=%0d want 0/1/1", vote_ack, rd_count, total); end
    endtask

    task automatic test_invalid();
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 12, 0);
        compared++; if (vote_err !== 1'b1 || armed !== 1'b1 || vote_ack !== 1'b0) begin mismatched++; $display("FAIL bad_index: got err=%0b armed=%0b ack=%0b want 1/1/0", vote_err, armed, vote_ack); end
        step(0, 1, 5, 0);
        rd_sel = 5; #1;
        compared++; if (vote_ack !== 1'b1 || vote_err !== 1'b0 || rd_count !== 2'd1) begin mismatched++; $display("FAIL after_bad: got ack=%0b err=%0b cnt=%0d want 1/0/1", vote_ack, vote_err, rd_count); end
        step(0, 1, 12, 0);
        compared++; if (vote_err !== 1'b0) begin mismatched++; $display("FAIL locked_bad_index: got err=%0b want 0", vote_err); end
    endtask

    task automatic test_timeout();
        do_reset();
        step(1, 0, 0, 0);
        for (int k = 1; k < TO; k++) begin
            step(0, 0, 0, 0);
            compared++; if (timeout !== 1'b0 || armed !== 1'b1) begin mismatched++; $display("FAIL wait_%0d: got to=%0b armed=%0b want 0/1", k, timeout, armed); end
        end
        step(0, 0, 0, 0);
        compared++; if (timeout !== 1'b1 || armed !== 1'b0 || total !== 5'd0) begin mismatched++; $display("FAIL expire: got to=%0b armed=%0b tot=%0d want 1/0/0", timeout, armed, total); end
        step(0, 0, 0, 0);
        compared++; if (timeout !== 1'b0) begin mismatched++; $display("FAIL expire_pulse: got %0b want 0", timeout); end
        step(1, 0, 0, 0);
        for (int k = 1; k < TO; k++) step(k == 2, 0, 0, 0);
        step(0, 1, 2, 0);
        compared++; if (vote_ack !== 1'b1 || timeout !== 1'b0 || total !== 5'd1) begin mismatched++; $display("FAIL last_cycle_vote: got ack=%0b to=%0b tot=%0d want 1/0/1", vote_ack, timeout, total); end
    endtask

    task automatic test_leader();
        do_reset();
        step(1, 0, 0, 0); step(0, 1, 2, 0);
        step(1, 0, 0, 0); step(0, 1, 7, 0);
        compared++; if (leader !== 4'd2 || tie !== 1'b1 || leader_count !== 2'd1) begin mismatched++; $display("FAIL tie: got %0d/%0d/%0b want 2/1/1", leader, leader_count, tie); end
        step(1, 0, 0, 0); step(0, 1, 7, 0);
        compared++; if (leader !== 4'd7 || leader_count !== 2'd2 || tie !== 1'b0) begin mismatched++; $display("FAIL overtake: got %0d/%0d/%0b want 7/2/0", leader, leader_count, tie); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 0);
            step(0, 1, 1, 0);
            compared++; if (vote_ack !== 1'b1) begin mismatched++; $display("FAIL sat_ack%0d: got %0b want 1", k, vote_ack); end
        end
        rd_sel = 1; #1;
        compared++; if (rd_count !== 2'd3 || total !== 5'd4 || sat !== 1'b1) begin mismatched++; $display("FAIL saturate: got cnt=%0d tot=%0d sat=%0b want 3/4/1", rd_count, total, sat); end
        compared++; if (leader !== 4'd1 || leader_count !== 2'd3) begin mismatched++; $display("FAIL sat_leader: got %0d/%0d want 1/3", leader, leader_count); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset();
            step(($urandom % 3) == 0, $urandom % 2, 4'($urandom_range(0, 15)), 0);
            rd_sel = 4'($urandom_range(0, 15)); #1;
            compared++;
            if ({vote_ack, vote_err, timeout, armed, poll_closed} !== {e_ack, e_err, e_to, m_armed, m_closed}) begin
                mismatched++; $display("FAIL rnd_flags@%0d: got %b want %b", k, {vote_ack, vote_err, timeout, armed, poll_closed}, {e_ack, e_err, e_to, m_armed, m_closed});
            end
            compared++;
            if (total !== m_total || sat !== m_sat) begin
                mismatched++; $display("FAIL rnd_total@%0d: got %0d/%0b want %0d/%0b", k, total, sat, m_total, m_sat);
            end
            compared++;
            if (leader !== m_leader || leader_count !== m_lc || tie !== m_tie) begin
                mismatched++; $display("FAIL rnd_leader@%0d: got %0d/%0d/%0b want %0d/%0d/%0b", k, leader, leader_count, tie, m_leader, m_lc, m_tie);
            end
            compared++;
            if (rd_count !== exp_rd(rd_sel)) begin
                mismatched++; $display("FAIL rnd_rd@%0d sel %0d: got %0d want %0d", k, rd_sel, rd_count, exp_rd(rd_sel));
            end
        end
    endtask

    task automatic test_close();
        do_reset();
        step(1, 0, 0, 0); step(0, 1, 6, 0);
        step(1, 0, 0, 0); step(0, 1, 4, 1);
        compared++; if (poll_closed !== 1'b1 || vote_ack !== 1'b0 || total !== 5'd1) begin mismatched++; $display("FAIL close_vote: got closed=%0b ack=%0b tot=%0d want 1/0/1", poll_closed, vote_ack, total); end
        step(1, 0, 0, 0); step(0, 1, 6, 0); step(1, 1, 6, 0);
        compared++; if (armed !== 1'b0 || vote_ack !== 1'b0 || total !== 5'd1 || poll_closed !== 1'b1) begin mismatched++; $display("FAIL closed_ignore: got armed=%0b ack=%0b tot=%0d closed=%0b want 0/0/1/1", armed, vote_ack, total, poll_closed); end
        for (int s = 0; s < 16; s++) begin
            rd_sel = 4'(s); #1;
            compared++; if (rd_count !== exp_rd(4'(s)) || rd_count !== ((s == 6) ? 2'd1 : 2'd0)) begin mismatched++; $display("FAIL frozen_rd[%0d]: got %0d want %0d", s, rd_count, exp_rd(4'(s))); end
        end
        do_reset();
        rd_sel = 6; #1;
        compared++; if (poll_closed !== 1'b0 || armed !== 1'b0 || total !== 5'd0 || rd_count !== 2'd0) begin mismatched++; $display("FAIL reopen: got closed=%0b armed=%0b tot=%0d cnt=%0d want 0/0/0/0", poll_closed, armed, total, rd_count); end
    endtask

    initial begin
        test_reset();
        test_basic_vote();
        test_invalid();
        test_timeout();
        test_leader();
        test_saturation();
        test_random();
        test_close();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
